// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-master arbiter/sequencer in front of the single-port data memory bank.
//   m0 = CPU load/store path, m1 = loader/debug port.
//   Each transaction walks IDLE -> ACCESS -> RESP. All memory controls, acks,
//   read data and counters come straight from flops.
//
//   Build option:
//     DMEM_ARB_RR_EN  defined   -> round-robin on ties (last_gnt register built)
//                     undefined -> fixed priority, m0 always beats m1
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;

    // Winner selection
    logic                gnt_valid_s;
    logic                gnt_sel_s;
    logic                we_sel_s;
    logic [ADDR_W-1:0]   addr_sel_s;
    logic [DATA_W-1:0]   wdata_sel_s;

    // Latched transaction
    logic                owner_r;
    logic                we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;

    // Next values of registered outputs
    logic                latch_s;
    logic                mem_read_s;
    logic                mem_write_s;
    logic                ack0_s;
    logic                ack1_s;
    logic                cap_s;
    logic                busy_s;

    // Registered outputs
    logic                mem_read_r;
    logic                mem_write_r;
    logic                ack0_r;
    logic                ack1_r;
    logic                busy_r;
    logic [DATA_W-1:0]   m0_rdata_r;
    logic [DATA_W-1:0]   m1_rdata_r;
    logic [CNT_W-1:0]    gnt_cnt0_r;
    logic [CNT_W-1:0]    gnt_cnt1_r;

`ifdef DMEM_ARB_RR_EN
    logic                last_gnt_r;

    // Round-robin winner: on a tie grant the port that did not win last time
    always_comb begin
        gnt_valid_s = m0_req | m1_req;
        gnt_sel_s   = 1'b0;
        if (m0_req && m1_req) begin
            gnt_sel_s = ~last_gnt_r;
        end else if (m1_req) begin
            gnt_sel_s = 1'b1;
        end else begin
            gnt_sel_s = 1'b0;
        end
    end

    // Remember the most recent grant; reset to m1 so m0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_r <= 1'b1;
        end else if (latch_s) begin
            last_gnt_r <= gnt_sel_s;
        end
    end
`else
    // Fixed-priority winner: m0 always beats m1
    always_comb begin
        gnt_valid_s = m0_req | m1_req;
        gnt_sel_s   = 1'b0;
        if (m0_req) begin
            gnt_sel_s = 1'b0;
        end else if (m1_req) begin
            gnt_sel_s = 1'b1;
        end else begin
            gnt_sel_s = 1'b0;
        end
    end
`endif

    // Mux the winning requester's command fields
    always_comb begin
        we_sel_s    = 1'b0;
        addr_sel_s  = {ADDR_W{1'b0}};
        wdata_sel_s = {DATA_W{1'b0}};
        if (gnt_sel_s) begin
            we_sel_s    = m1_we;
            addr_sel_s  = m1_addr;
            wdata_sel_s = m1_wdata;
        end else begin
            we_sel_s    = m0_we;
            addr_sel_s  = m0_addr;
            wdata_sel_s = m0_wdata;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic: ACCESS and RESP each last exactly one cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_s = ST_RESP;
            ST_RESP:   state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values for the registered controls
    always_comb begin
        latch_s     = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        ack0_s      = 1'b0;
        ack1_s      = 1'b0;
        cap_s       = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    latch_s     = 1'b1;
                    mem_read_s  = ~we_sel_s;
                    mem_write_s = we_sel_s;
                    busy_s      = 1'b1;
                end else begin
                    latch_s     = 1'b0;
                end
            end
            ST_ACCESS: begin
                ack0_s = ~owner_r;
                ack1_s = owner_r;
                cap_s  = ~we_r;
                busy_s = 1'b1;
            end
            ST_RESP: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Latch the granted command; mem_addr/mem_wdata hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r     <= 1'b0;
            we_r        <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (latch_s) begin
            owner_r     <= gnt_sel_s;
            we_r        <= we_sel_s;
            mem_addr_r  <= addr_sel_s;
            mem_wdata_r <= wdata_sel_s;
        end
    end

    // Register memory strobes, acks and busy so nothing downstream glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            mem_read_r  <= mem_read_s;
            mem_write_r <= mem_write_s;
            ack0_r      <= ack0_s;
            ack1_r      <= ack1_s;
            busy_r      <= busy_s;
        end
    end

    // Capture read data into the owner's register; writes leave it alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rdata_r <= {DATA_W{1'b0}};
            m1_rdata_r <= {DATA_W{1'b0}};
        end else if (cap_s) begin
            if (owner_r) begin
                m1_rdata_r <= mem_rdata;
            end else begin
                m0_rdata_r <= mem_rdata;
            end
        end
    end

    // Per-port completion counters, wrapping silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_r <= {CNT_W{1'b0}};
            gnt_cnt1_r <= {CNT_W{1'b0}};
        end else begin
            if (ack0_s) begin
                gnt_cnt0_r <= gnt_cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (ack1_s) begin
                gnt_cnt1_r <= gnt_cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign m0_ack    = ack0_r;
    assign m1_ack    = ack1_r;
    assign m0_rdata  = m0_rdata_r;
    assign m1_rdata  = m1_rdata_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign gnt_cnt0  = gnt_cnt0_r;
    assign gnt_cnt1  = gnt_cnt1_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed self-checking bench for dmem_arbiter with a behavioural memory
//   (combinational read, clocked write). Built with CNT_W=4 so the counter
//   wrap is reachable. Honours DMEM_ARB_RR_EN for the tie-break expectations.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic              m0_ack, m1_ack;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;
    logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cycles = 0;

    // Memory model with a preload port used during reset
    logic [DATA_W-1:0] mem [0:255];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = mem[mem_addr];

    // Memory write port and preload
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    // Per-cycle protocol invariants (ACCESS == busy without an ack)
    always @(negedge clk) begin
        if (mem_write) wr_cycles <= wr_cycles + 1;
        n_checks = n_checks + 3;
        assert (!(mem_read && mem_write)) else begin
            n_fail = n_fail + 1;
            $error("FAIL rd_wr_excl: observed rd=%0b wr=%0b expected not both", mem_read, mem_write);
        end
        assert (!(m0_ack && m1_ack)) else begin
            n_fail = n_fail + 1;
            $error("FAIL ack_excl: observed both acks high expected at most one");
        end
        assert (!mem_write || (busy && !m0_ack && !m1_ack)) else begin
            n_fail = n_fail + 1;
            $error("FAIL wr_in_access: observed mem_write=1 busy=%0b acks=%0b%0b expected only in ACCESS",
                   busy, m0_ack, m1_ack);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
        chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
        chk({tag, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_acks"}, {30'd0, m0_ack, m1_ack}, 32'd0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_cnts"}, {24'd0, gnt_cnt1, gnt_cnt0}, 32'd0);
    endtask

    // One complete transaction on a port; req drops during the ack cycle
    task automatic do_txn(input logic port, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, output logic [DATA_W-1:0] rdata);
        logic got;
        got = 1'b0;
        if (port) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            step();
            got = port ? m1_ack : m0_ack;
        end
        chk("txn_ack_seen", {31'd0, got}, 32'd1);
        rdata = port ? m1_rdata : m0_rdata;
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [DATA_W-1:0] rd;
    logic              e0, e1;

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #1;
        chk_all_zero("reset");

        // Preload memory while in reset
        pl_en = 1'b1;
        pl_addr = 8'd2; pl_data = 32'd8;  step();
        pl_addr = 8'd0; pl_data = 32'd7;  step();
        pl_addr = 8'd5; pl_data = 32'd10; step();
        pl_en = 1'b0;
        rst_n = 1'b1;
        step();
        chk_all_zero("post_reset_idle");

        // m0 read of address 2, cycle by cycle
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'd2;
        step();
        chk("rd2_mem_read", {31'd0, mem_read}, 32'd1);
        chk("rd2_mem_addr", {24'd0, mem_addr}, 32'd2);
        chk("rd2_busy", {31'd0, busy}, 32'd1);
        chk("rd2_no_ack_yet", {31'd0, m0_ack}, 32'd0);
        step();
        chk("rd2_ack", {30'd0, m0_ack, m1_ack}, 32'd2);
        chk("rd2_rdata", m0_rdata, 32'd8);
        chk("rd2_cnt0", {28'd0, gnt_cnt0}, 32'd1);
        chk("rd2_mem_read_clr", {31'd0, mem_read}, 32'd0);
        chk("rd2_busy_resp", {31'd0, busy}, 32'd1);
        m0_req = 1'b0;
        step();
        chk("rd2_ack_pulse", {31'd0, m0_ack}, 32'd0);
        chk("rd2_idle", {31'd0, busy}, 32'd0);
        step();
        chk("rd2_no_repeat", {31'd0, mem_read}, 32'd0);

        // m1 write 0xDEADBEEF to address 9
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'd9; m1_wdata = 32'hDEADBEEF;
        step();
        chk("wr9_mem_write", {31'd0, mem_write}, 32'd1);
        chk("wr9_mem_read", {31'd0, mem_read}, 32'd0);
        chk("wr9_mem_addr", {24'd0, mem_addr}, 32'd9);
        chk("wr9_mem_wdata", mem_wdata, 32'hDEADBEEF);
        step();
        chk("wr9_mem_write_clr", {31'd0, mem_write}, 32'd0);
        chk("wr9_ack", {30'd0, m0_ack, m1_ack}, 32'd1);
        chk("wr9_cnt1", {28'd0, gnt_cnt1}, 32'd1);
        chk("wr9_m1_rdata_kept", m1_rdata, 32'd0);
        m1_req = 1'b0;
        step();

        // m0 reads back address 9
        do_txn(1'b0, 1'b0, 8'd9, 32'd0, rd);
        chk("rd9_rdata", rd, 32'hDEADBEEF);
        chk("rd9_cnt0", {28'd0, gnt_cnt0}, 32'd2);
        chk("rd9_m1_rdata_kept", m1_rdata, 32'd0);
        chk("rd9_addr_hold", {24'd0, mem_addr}, 32'd9);
        chk("wr_one_cycle", wr_cycles, 32'd1);

        // Request withdrawn before any edge samples it
        m0_req = 1'b1; m0_addr = 8'd5;
        #3;
        m0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("withdraw_no_access", {29'd0, busy, mem_read, m0_ack}, 32'd0);
        end
        chk("withdraw_cnt0", {28'd0, gnt_cnt0}, 32'd2);

        // Reset asserted in the middle of a write ACCESS
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'd20; m0_wdata = 32'h12345678;
        step();
        chk("mid_rst_pre_write", {31'd0, mem_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        m0_req = 1'b0; m0_we = 1'b0;
        step();
        step();
        chk("mid_rst_no_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
        rst_n = 1'b1;
        step();
        chk_all_zero("mid_rst_release");

        // Both ports requesting continuously: m0 reads 0, m1 reads 5
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'd0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'd5;
        for (int k = 1; k <= 12; k++) begin
            step();
`ifdef DMEM_ARB_RR_EN
            e0 = (k == 2) || (k == 8);
            e1 = (k == 5) || (k == 11);
`else
            e0 = (k % 3) == 2;
            e1 = 1'b0;
`endif
            chk("tie_m0_ack", {31'd0, m0_ack}, {31'd0, e0});
            chk("tie_m1_ack", {31'd0, m1_ack}, {31'd0, e1});
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        chk("tie_m0_rdata", m0_rdata, 32'd7);
`ifdef DMEM_ARB_RR_EN
        chk("tie_m1_rdata", m1_rdata, 32'd10);
        chk("tie_cnts", {24'd0, gnt_cnt1, gnt_cnt0}, {24'd0, 4'd2, 4'd2});
`else
        chk("tie_m1_rdata", m1_rdata, 32'd0);
        chk("tie_cnts", {24'd0, gnt_cnt1, gnt_cnt0}, {24'd0, 4'd0, 4'd4});
`endif
        step();
        step();
        chk("tie_back_idle", {31'd0, busy}, 32'd0);

        // Counter wrap: 15 transactions then one more
        apply_reset();
        step();
        for (int i = 0; i < 15; i++) begin
            do_txn(1'b0, 1'b1, 8'd30, 32'(i), rd);
        end
        chk("wrap_cnt0_max", {28'd0, gnt_cnt0}, 32'd15);
        do_txn(1'b0, 1'b1, 8'd30, 32'd99, rd);
        chk("wrap_cnt0_zero", {28'd0, gnt_cnt0}, 32'd0);
        chk("wrap_cnt1", {28'd0, gnt_cnt1}, 32'd0);
        chk("wrap_last_write", mem[30], 32'd99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
